fetch_ctrl: RTL and testbench

Sequencing controller for the instruction fetch stage. Each cycle it generates the fetch-stage controls `pc_en`, `flush`, `jump_en` and `pc_jump_addr` from:
- hazard stalls;
- decode-stage jumps;
- execute-stage branch redirects (mispredict recovery);
- halt requests.

It runs a post-reset boot hold-off and qualifies fetched instructions with `if_valid`. It keeps a saturating count of execute redirects.

---
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl: IF-stage sequencing (boot hold-off, redirects, stall, halt)
// Revision: 1.0
// ============================================================================
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_redirect_valid,
  input  logic [31:0] ex_redirect_pc,
  input  logic        id_jump_valid,
  input  logic [31:0] id_jump_pc,
  input  logic        halt_req,
  output logic        pc_en,
  output logic        flush,
  output logic        jump_en,
  output logic [31:0] pc_jump_addr,
  output logic        if_valid,
  output logic [15:0] redirect_cnt
);

  // A zero-length hold-off still spends the first post-reset cycle in BOOT,
  // so it behaves exactly like a one-cycle hold-off.
  localparam int BOOT_LAST = (BOOT_CYCLES < 1) ? 0 : BOOT_CYCLES - 1;
  localparam int CNT_W     = (BOOT_LAST < 1) ? 1 : $clog2(BOOT_LAST + 1);
  localparam logic [CNT_W-1:0] BOOT_LAST_C = CNT_W'(BOOT_LAST);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [15:0]      redirect_cnt_q, redirect_cnt_d;

  logic        redirect_ok;
  logic        accept_ex;
  logic        accept_id;
  logic        accept;
  logic        pc_en_raw;
  logic [31:0] jump_addr_raw;

  assign redirect_ok = (state_q == RUN) || (state_q == REDIRECT);
  assign accept_ex   = redirect_ok && ex_redirect_valid;
  assign accept_id   = redirect_ok && id_jump_valid && !ex_redirect_valid;
  assign accept      = accept_ex || accept_id;

  always_comb begin
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    pc_en_raw      = 1'b0;
    jump_addr_raw  = 32'd0;

    if (accept_ex) begin
      jump_addr_raw = ex_redirect_pc;
      if (redirect_cnt_q != 16'hFFFF) begin
        redirect_cnt_d = redirect_cnt_q + 16'd1;
      end
    end else if (accept_id) begin
      jump_addr_raw = id_jump_pc;
    end

    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + CNT_W'(1);
        if (boot_cnt_q == BOOT_LAST_C) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          pc_en_raw = 1'b1;
          state_d   = REDIRECT;
        end else if (halt_req) begin
          state_d = HALT;
        end else begin
          pc_en_raw = !stall;
        end
      end
      REDIRECT: begin
        if (accept) begin
          pc_en_raw = 1'b1;
        end else begin
          pc_en_raw = !stall;
          if (!stall) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BOOT;
      boot_cnt_q     <= '0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      boot_cnt_q     <= boot_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // Reset masks every output, even before the first edge sets the state.
  assign pc_en        = !rst && pc_en_raw;
  assign flush        = !rst && accept;
  assign jump_en      = !rst && accept;
  assign pc_jump_addr = rst ? 32'd0 : jump_addr_raw;
  assign if_valid     = !rst && (state_q == RUN);
  assign redirect_cnt = rst ? 16'd0 : redirect_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// Directed bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_redirect_valid;
  logic [31:0] ex_redirect_pc;
  logic        id_jump_valid;
  logic [31:0] id_jump_pc;
  logic        halt_req;
  logic        pc_en;
  logic        flush;
  logic        jump_en;
  logic [31:0] pc_jump_addr;
  logic        if_valid;
  logic [15:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.BOOT_CYCLES(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .ex_redirect_valid (ex_redirect_valid),
    .ex_redirect_pc    (ex_redirect_pc),
    .id_jump_valid     (id_jump_valid),
    .id_jump_pc        (id_jump_pc),
    .halt_req          (halt_req),
    .pc_en             (pc_en),
    .flush             (flush),
    .jump_en           (jump_en),
    .pc_jump_addr      (pc_jump_addr),
    .if_valid          (if_valid),
    .redirect_cnt      (redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are checked one unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic pe, input logic fl,
                          input logic je, input logic [31:0] addr, input logic iv);
    chk({tag, ".pc_en"},        {31'd0, pc_en},    {31'd0, pe});
    chk({tag, ".flush"},        {31'd0, flush},    {31'd0, fl});
    chk({tag, ".jump_en"},      {31'd0, jump_en},  {31'd0, je});
    chk({tag, ".pc_jump_addr"}, pc_jump_addr,      addr);
    chk({tag, ".if_valid"},     {31'd0, if_valid}, {31'd0, iv});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ex_redirect_valid = 1'b0; ex_redirect_pc = 32'd0;
    id_jump_valid = 1'b0; id_jump_pc = 32'd0; halt_req = 1'b0;
    tick(); tick();
    ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h55;
    settle();
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("reset.cnt", {16'd0, redirect_cnt}, 32'd0);
    ex_redirect_valid = 1'b0; ex_redirect_pc = 32'd0;

    // Boot hold-off: t=0..3 held, t=4 fetching
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      settle();
      chk_ctrl($sformatf("boot_t%0d", t), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end
    settle();
    chk_ctrl("boot_t4", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Stall in RUN
    stall = 1'b1;
    settle();
    chk_ctrl("run_stall", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();

    // Decode jump under stall
    id_jump_valid = 1'b1; id_jump_pc = 32'h80;
    settle();
    chk_ctrl("id_jump_stall", 1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
    tick();
    id_jump_valid = 1'b0; id_jump_pc = 32'd0;

    // Stall held 3 cycles in REDIRECT
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_ctrl($sformatf("redir_stall%0d", i), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end
    chk("id_jump_not_counted", {16'd0, redirect_cnt}, 32'd0);
    stall = 1'b0;
    settle();
    chk_ctrl("redir_release", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    chk_ctrl("back_to_run", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Execute redirect
    ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h40;
    settle();
    chk_ctrl("ex_redirect", 1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    tick();
    ex_redirect_valid = 1'b0; ex_redirect_pc = 32'd0;
    settle();
    chk_ctrl("ex_redirect_t1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("ex_redirect_cnt", {16'd0, redirect_cnt}, 32'd1);
    tick();
    chk_ctrl("ex_redirect_t2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Simultaneous execute + decode + halt: execute wins, halt dropped
    ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h100;
    id_jump_valid = 1'b1; id_jump_pc = 32'h200; halt_req = 1'b1;
    settle();
    chk_ctrl("simul", 1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
    tick();
    ex_redirect_valid = 1'b0; ex_redirect_pc = 32'd0;
    id_jump_valid = 1'b0; id_jump_pc = 32'd0; halt_req = 1'b0;
    settle();
    chk_ctrl("simul_t1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("simul_cnt", {16'd0, redirect_cnt}, 32'd2);
    tick();
    chk("simul_t2.if_valid", {31'd0, if_valid}, 32'd1);

    // Halt
    halt_req = 1'b1;
    settle();
    chk_ctrl("halt_req", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    halt_req = 1'b0;
    ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h44; id_jump_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_ctrl($sformatf("halted%0d", i), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end
    chk("halted_cnt", {16'd0, redirect_cnt}, 32'd2);
    ex_redirect_valid = 1'b0; ex_redirect_pc = 32'd0; id_jump_valid = 1'b0;

    // Reset out of HALT
    rst = 1'b1;
    settle();
    chk("halt_rst.cnt", {16'd0, redirect_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      settle();
      chk_ctrl($sformatf("reboot_t%0d", t), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end
    chk_ctrl("reboot_t4", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("reboot_cnt", {16'd0, redirect_cnt}, 32'd0);

    // Saturation: execute redirect every cycle, including from REDIRECT
    ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h1234;
    settle();
    chk_ctrl("sat_first", 1'b1, 1'b1, 1'b1, 32'h1234, 1'b1);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_65534", {16'd0, redirect_cnt}, 32'h0000FFFE);
    chk_ctrl("sat_in_redirect", 1'b1, 1'b1, 1'b1, 32'h1234, 1'b0);
    tick();
    chk("sat_65535", {16'd0, redirect_cnt}, 32'h0000FFFF);
    tick(); tick();
    chk("sat_65537", {16'd0, redirect_cnt}, 32'h0000FFFF);

    // Mid-operation reset
    rst = 1'b1;
    settle();
    chk_ctrl("mid_rst", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("mid_rst.cnt", {16'd0, redirect_cnt}, 32'd0);
    tick();
    rst = 1'b0; ex_redirect_valid = 1'b0; ex_redirect_pc = 32'd0;
    settle();
    chk("post_rst.cnt", {16'd0, redirect_cnt}, 32'd0);
    for (int t = 0; t < 4; t++) begin
      settle();
      chk_ctrl($sformatf("boot3_t%0d", t), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end
    chk_ctrl("boot3_t4", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
